// File: rtl/button_event_poller.sv
// Polls a two-button edge-capture PIO, clears the captured edges, applies a per-button
// lockout and presents new presses as a pending mask with sticky overflow.
module button_event_poller #(
    parameter int unsigned POLL_PERIOD   = 50000,
    parameter int unsigned LOCKOUT_POLLS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        evt_valid,
    output logic [1:0]  evt_mask,
    input  logic        evt_ready,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic        busy
);
    localparam int unsigned        TimerW      = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [TimerW-1:0]  TimerLast   = TimerW'(POLL_PERIOD - 1);
    localparam logic [7:0]         LockoutLoad = 8'(LOCKOUT_POLLS);
    localparam logic [1:0]         EdgeCapAddr = 2'd3;

    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StClr, StUpdate} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        cap_q, cap_d;
    logic [1:0][7:0]   lockout_q, lockout_d;
    logic [1:0]        pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        locked;
    logic [1:0]        new_evt;
    logic              accept;
    logic              overflow_set;
    logic              unused_rdata;

    assign unused_rdata = ^avm_readdata[31:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            cap_q      <= '0;
            lockout_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cap_q      <= cap_d;
            lockout_q  <= lockout_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            locked[i] = (lockout_q[i] != 8'd0);
        end
    end

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        lockout_d    = lockout_q;
        new_evt      = 2'b00;
        accept       = evt_valid & evt_ready;

        // Free-running while enabled so poll starts stay POLL_PERIOD apart.
        if (!enable || timer_q == TimerLast) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TimerW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (enable && timer_q == TimerLast) begin
                    state_d = StRdAddr;
                end
            end
            StRdAddr: state_d = StRdData;
            StRdData: begin
                cap_d   = avm_readdata[1:0];
                state_d = (avm_readdata[1:0] != 2'b00) ? StClr : StUpdate;
            end
            StClr: state_d = StUpdate;
            StUpdate: begin
                new_evt = cap_q & ~locked;
                for (int i = 0; i < 2; i++) begin
                    if (new_evt[i]) begin
                        lockout_d[i] = LockoutLoad;
                    end else if (locked[i]) begin
                        lockout_d[i] = lockout_q[i] - 8'd1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // An accept drains everything presented; a same-cycle new bit survives.
        pending_d    = (pending_q & ~(accept ? pending_q : 2'b00)) | new_evt;
        overflow_set = (|(new_evt & pending_q)) & ~accept;
        if (overflow_set) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_comb begin
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'h0;
        unique case (state_q)
            StRdAddr: begin
                avm_address    = EdgeCapAddr;
                avm_chipselect = 1'b1;
            end
            StClr: begin
                avm_address    = EdgeCapAddr;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {30'b0, cap_q};
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign evt_valid = |pending_q;
    assign evt_mask  = pending_q;
    assign overflow  = overflow_q;

endmodule
